// File: rtl/code_check_arbiter.sv
// code_check_arbiter: round-robin 2-requester arbiter that buffers 8 bytes and streams them to a shared sequence checker
module code_check_arbiter #(
   parameter int LOCKOUT      = 16,
   parameter int LOAD_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        clr,
   input  logic [1:0]  req_valid,
   input  logic [15:0] req_data,
   output logic [1:0]  req_ready,
   output logic [1:0]  res_valid,
   output logic        res_pass,
   output logic        chk_clr,
   output logic [7:0]  chk_d,
   input  logic [8:0]  chk_q,
   output logic        busy,
   output logic [1:0]  locked
);
   localparam int LW = $clog2(LOCKOUT + 1);
   localparam int TW = $clog2(LOAD_TIMEOUT + 1);
   typedef enum logic [2:0] {IDLE, LOAD, CLEAR, STREAM, WAIT, RESULT} state_t;
   state_t          r_state;
   logic            r_g, r_ptr, r_skip, r_pass, r_chk_clr;
   logic [3:0]      r_cnt;
   logic [TW-1:0]   r_to;
   logic [7:0]      r_buf [8];
   logic [7:0]      r_chk_d;
   logic [LW-1:0]   r_lock [2];
   logic [1:0]      r_ready, r_res_valid;
   logic [1:0]      w_elig;
   logic            w_gnt, w_acc;
   logic [7:0]      w_byte;
   logic            w_unused;
   assign w_elig    = req_valid & ~locked;
   assign w_gnt     = &w_elig ? ~r_ptr : w_elig[1];
   assign w_acc     = |(req_valid & r_ready);
   assign w_byte    = r_g ? req_data[15:8] : req_data[7:0];
   assign w_unused  = ^chk_q[7:0];
   assign req_ready = r_ready;
   assign res_valid = r_res_valid;
   assign res_pass  = r_pass;
   assign chk_clr   = r_chk_clr;
   assign chk_d     = r_chk_d;
   assign busy      = r_state != IDLE;
   assign locked    = {|r_lock[1], |r_lock[0]};
   always_ff @(posedge clk) begin
      if (clr) begin
         r_state     <= IDLE;
         r_g         <= 1'b0;
         r_ptr       <= 1'b1;
         r_skip      <= 1'b0;
         r_pass      <= 1'b0;
         r_chk_clr   <= 1'b1;
         r_chk_d     <= '0;
         r_cnt       <= '0;
         r_to        <= '0;
         r_ready     <= '0;
         r_res_valid <= '0;
         for (int i = 0; i < 2; i++) r_lock[i] <= '0;
         for (int i = 0; i < 8; i++) r_buf[i] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) if (r_lock[i] != '0) r_lock[i] <= r_lock[i] - LW'(1);
         case (r_state)
            IDLE: if (|w_elig) begin
               r_g     <= w_gnt;
               r_ptr   <= w_gnt;
               r_cnt   <= '0;
               r_to    <= '0;
               r_ready <= {w_gnt, ~w_gnt};
               r_state <= LOAD;
            end
            LOAD: if (w_acc) begin
               r_buf[r_cnt[2:0]] <= w_byte;
               r_cnt <= r_cnt + 4'd1;
               r_to  <= '0;
               if (r_cnt == 4'd7) begin
                  r_ready <= '0;
                  r_state <= CLEAR;
               end
            end else if (r_to == TW'(LOAD_TIMEOUT - 1)) begin
               // abandoned load reports a failure but must not lock the requester out
               r_ready     <= '0;
               r_res_valid <= {r_g, ~r_g};
               r_pass      <= 1'b0;
               r_skip      <= 1'b1;
               r_chk_clr   <= 1'b0;
               r_state     <= RESULT;
            end else begin
               r_to <= r_to + TW'(1);
            end
            CLEAR: begin
               r_chk_clr <= 1'b0;
               r_chk_d   <= r_buf[0];
               r_cnt     <= 4'd1;
               r_state   <= STREAM;
            end
            STREAM: if (r_cnt == 4'd8) begin
               r_chk_d <= '0;
               r_state <= WAIT;
            end else begin
               r_chk_d <= r_buf[r_cnt[2:0]];
               r_cnt   <= r_cnt + 4'd1;
            end
            WAIT: begin
               // full-match flag is valid only in the cycle after the last byte
               r_res_valid <= {r_g, ~r_g};
               r_pass      <= chk_q[8];
               r_skip      <= 1'b0;
               r_state     <= RESULT;
            end
            RESULT: begin
               r_res_valid <= '0;
               r_pass      <= 1'b0;
               r_chk_clr   <= 1'b1;
               r_state     <= IDLE;
               if (!r_pass && !r_skip) r_lock[r_g] <= LW'(LOCKOUT);
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/code_check_arbiter.md
CODE_CHECK_ARBITER -- requirements
Module: code_check_arbiter

Interface
REQ-001 The block SHALL provide parameter LOCKOUT, default 16, the number of cycles a requester is barred after a failed check.
REQ-002 The block SHALL provide parameter LOAD_TIMEOUT, default 64, the maximum consecutive LOAD cycles allowed with no byte accepted.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 clr  in  1  reset, synchronous and active-high.
REQ-005 req_valid  in  2  per-requester byte valid; bit i belongs to requester i.
REQ-006 req_data  in  16  per-requester byte; [7:0] is requester 0, [15:8] is requester 1.
REQ-007 req_ready  out  2  per-requester byte accept.
REQ-008 res_valid  out  2  one-cycle result strobe per requester.
REQ-009 res_pass  out  1  check result; meaningful only while any res_valid bit is 1, otherwise 0.
REQ-010 chk_clr  out  1  clear to the shared 8-byte sequence checker.
REQ-011 chk_d  out  8  byte to the checker.
REQ-012 chk_q  in  9  checker stage outputs; only chk_q[8] (full-match flag) is used.
REQ-013 busy  out  1  high whenever state is not IDLE.
REQ-014 locked  out  2  bit i high while requester i's lockout counter is nonzero.

Function
REQ-015 The FSM SHALL have states IDLE, LOAD, CLEAR, STREAM, WAIT, RESULT.
REQ-016 IDLE: chk_clr=1, chk_d=0, req_ready=0; eligible = req_valid & ~locked.
REQ-017 Arbitration: one eligible requester -> grant it; both eligible -> grant the one not granted last (round-robin pointer); none eligible -> stay in IDLE.
REQ-018 A grant SHALL register the granted index g, update the pointer to g, clear byte count and timeout count, and move to LOAD on the next cycle.
REQ-019 LOAD: req_ready[g]=1 and the other bit 0; a byte is accepted on req_valid[g]&req_ready[g] and stored in buf[cnt], cnt increments.
REQ-020 On the 8th accepted byte, the FSM SHALL move to CLEAR and drop req_ready the following cycle.
REQ-021 LOAD timeout: after LOAD_TIMEOUT consecutive cycles with no accept, the block SHALL pulse res_valid[g]=1, res_pass=0, skip lockout, and return to IDLE.
REQ-022 CLEAR: exactly one cycle with chk_clr=1, chk_d=0, then STREAM.
REQ-023 STREAM: exactly 8 consecutive cycles, chk_clr=0, chk_d=buf[0]..buf[7] in order, with no gaps; the checker requires back-to-back bytes.
REQ-024 WAIT: one cycle, chk_clr=0, chk_d=0.
REQ-025 RESULT: one cycle; res_valid[g]=1, res_pass=chk_q[8], chk_clr=0; then IDLE.
REQ-026 Minimum transaction latency SHALL be 1 grant + 8 LOAD + 1 CLEAR + 8 STREAM + 1 WAIT + 1 RESULT = 20 cycles.
REQ-027 On res_pass=0 from RESULT, lockout counter g SHALL load LOCKOUT.
REQ-028 Each nonzero lockout counter SHALL decrement by 1 per cycle and saturate at 0.
REQ-029 Only the granted requester SHALL ever see req_ready or res_valid; the other requester's req_valid is held off until a later grant.
REQ-030 When both requesters are locked, no grant SHALL occur; the FSM stays in IDLE.
REQ-031 A lockout expiring in the same cycle a request is pending SHALL make that requester eligible on the following cycle.

Reset
REQ-032 clr=1 at a clock edge SHALL force, on the next cycle: state IDLE, chk_clr=1, chk_d=0, req_ready=0, res_valid=0, res_pass=0, busy=0, locked=0, all counters 0, and the pointer set so requester 0 wins the first tie.
REQ-033 clr asserted in any non-IDLE state SHALL abandon the transaction with no res_valid pulse and discard buffered bytes.

Verification
REQ-034 Req0 sends 6E 30 5F 73 50 31 63 33 back-to-back -> chk_d streams the same bytes in 8 consecutive cycles; res_valid=01, res_pass=1 at cycle 20.
REQ-035 Req1 sends 6E 30 5F 73 50 31 63 34 -> res_valid=10, res_pass=0; locked[1]=1 for 16 cycles, during which req_valid[1] gets no grant.
REQ-036 Both req_valid high from reset -> grant order 0, 1, 0 across three transactions.
REQ-037 Req0 sends 3 bytes, then idles 64 cycles -> res_valid=01, res_pass=0 with no lockout; req1 is granted next.
REQ-038 clr pulsed mid-STREAM -> next cycle state IDLE, chk_clr=1, no res_valid; a fresh correct sequence then passes.
REQ-039 Req0 sends the correct bytes with req_valid gaps during LOAD -> STREAM is still gapless and res_pass=1.
